// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: program counter, sequential PC+4,
// instruction-memory address and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic [31:0] npc,
  output logic [31:0] add4,
  output logic [31:0] pc_f,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        fetch_err_d
);

  // Upper bound is kept in 33 bits so a window ending at 2^32 cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  function automatic logic fetch_bad(input logic [31:0] addr);
    fetch_bad = (addr[1:0] != 2'b00) || (addr < IM_BASE) ||
                ({1'b0, addr} >= IM_LIMIT);
  endfunction

  logic [31:0] pc_r;
  logic        bad_s;
  logic [31:0] fetched_s;
  logic [31:0] pc4_s;
  logic [31:0] pc8_s;

  // Fetch address check and nop substitution for bad fetches.
  always_comb begin
    bad_s = fetch_bad(pc_r);
    pc4_s = pc_r + 32'd4;
    pc8_s = pc_r + 32'd8;
    if (bad_s) begin
      fetched_s = 32'h0000_0000;
    end else begin
      fetched_s = imem_rdata;
    end
  end

  // Program counter: loads the selected next PC unless the hazard unit stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (!stall) begin
      pc_r <= npc;
    end else begin
      pc_r <= pc_r;
    end
  end

  // IF/ID register: flush beats stall, stall beats normal capture.
  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      instr_d     <= 32'h0000_0000;
      pc_d        <= 32'h0000_0000;
      pc4_d       <= 32'h0000_0000;
      pc8_d       <= 32'h0000_0000;
      valid_d     <= 1'b0;
      fetch_err_d <= 1'b0;
    end else if (!stall) begin
      instr_d     <= fetched_s;
      pc_d        <= pc_r;
      pc4_d       <= pc4_s;
      pc8_d       <= pc8_s;
      valid_d     <= 1'b1;
      fetch_err_d <= bad_s;
    end else begin
      instr_d     <= instr_d;
      pc_d        <= pc_d;
      pc4_d       <= pc4_d;
      pc8_d       <= pc8_d;
      valid_d     <= valid_d;
      fetch_err_d <= fetch_err_d;
    end
  end

  assign pc_f      = pc_r;
  assign imem_addr = pc_r;
  assign add4      = pc4_s;

endmodule
